// File: rtl/vec_out_pkg.sv
// Shared types and sizing for the vector output scheduler.
package vec_out_pkg;

    localparam int unsigned DATA_WIDTH   = 19;
    localparam int unsigned VECTOR_SIZE  = 6;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned STALL_MARGIN = 1;

    localparam int unsigned VECTOR_W   = DATA_WIDTH * VECTOR_SIZE;
    localparam int unsigned LANE_IDX_W = $clog2(VECTOR_SIZE);
    localparam int unsigned COUNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef logic [DATA_WIDTH-1:0] lane_t;
    typedef logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] vector_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

endpackage

// File: rtl/vector_fifo.sv
// Whole-vector FIFO with wrap-around pointers and an occupancy count.
module vector_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    assign head  = mem[rdPtr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Pointer and occupancy tracking; a push into a full FIFO is legal only alongside a pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/vector_output_scheduler.sv
// Buffers CPU output vectors and streams them one lane at a time to a valid/ready sink.
module vector_output_scheduler
    import vec_out_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  outFlag,
    input  logic [VECTOR_W-1:0]   out,
    input  logic                  laneReady,
    output logic                  laneValid,
    output logic [DATA_WIDTH-1:0] laneData,
    output logic [LANE_IDX_W-1:0] laneIndex,
    output logic                  lastLane,
    output logic                  stallOut,
    output logic [COUNT_W-1:0]    fifoCount,
    output logic                  overflow
);

    sched_state_t            state;
    vector_t                 shiftReg;
    vector_t                 headVec;
    logic [VECTOR_W-1:0]     headFlat;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic                    doPop;
    logic                    doPush;
    logic [COUNT_W-1:0]      nextCount;
    logic [LANE_IDX_W-1:0]   nextIndex;

    assign headVec = vector_t'(headFlat);

    vector_fifo #(
        .WIDTH (VECTOR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (doPush),
        .pop      (doPop),
        .pushData (out),
        .head     (headFlat),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Pop/push decisions and the occupancy the FIFO will hold after this edge.
    always_comb begin
        doPop     = 1'b0;
        doPush    = 1'b0;
        nextCount = fifoCount;
        nextIndex = laneIndex + LANE_IDX_W'(1);
        if (!fifoEmpty) begin
            doPop = (state == IDLE) || (laneReady && lastLane);
        end
        doPush = outFlag && (!fifoFull || doPop);
        if (doPush && !doPop) begin
            nextCount = fifoCount + COUNT_W'(1);
        end else if (doPop && !doPush) begin
            nextCount = fifoCount - COUNT_W'(1);
        end
    end

    // Lane sequencer: loads the head vector and walks its lanes under the sink handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shiftReg  <= '0;
            laneValid <= 1'b0;
            laneData  <= '0;
            laneIndex <= '0;
            lastLane  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (doPop) begin
                        shiftReg  <= headVec;
                        laneData  <= headVec[0];
                        laneIndex <= '0;
                        lastLane  <= 1'(VECTOR_SIZE == 1);
                        laneValid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (laneReady) begin
                        if (!lastLane) begin
                            laneIndex <= nextIndex;
                            laneData  <= shiftReg[nextIndex];
                            lastLane  <= (nextIndex == LANE_IDX_W'(VECTOR_SIZE - 1));
                        end else if (doPop) begin
                            shiftReg  <= headVec;
                            laneData  <= headVec[0];
                            laneIndex <= '0;
                            lastLane  <= 1'(VECTOR_SIZE == 1);
                        end else begin
                            laneValid <= 1'b0;
                            laneData  <= '0;
                            laneIndex <= '0;
                            lastLane  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    laneValid <= 1'b0;
                end
            endcase
        end
    end

    // Stall request from upcoming occupancy, and the sticky drop flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            stallOut <= (nextCount >= COUNT_W'(FIFO_DEPTH - STALL_MARGIN));
            if (outFlag && !doPush) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_output_scheduler.sv
// Self-checking bench for vector_output_scheduler with a queue-based reference model.
module tb_vector_output_scheduler;
    import vec_out_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  outFlag = 1'b0;
    logic [VECTOR_W-1:0]   outBus = '0;
    logic                  laneReady = 1'b0;
    logic                  laneValid;
    logic [DATA_WIDTH-1:0] laneData;
    logic [LANE_IDX_W-1:0] laneIndex;
    logic                  lastLane;
    logic                  stallOut;
    logic [COUNT_W-1:0]    fifoCount;
    logic                  overflow;

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Reference model: queued vectors, the vector being sent and its lane position.
    vector_t mq[$];
    bit      mBusy;
    vector_t mCur;
    int      mLane;
    bit      mOvf;

    always #5 clock = ~clock;

    vector_output_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .outFlag   (outFlag),
        .out       (outBus),
        .laneReady (laneReady),
        .laneValid (laneValid),
        .laneData  (laneData),
        .laneIndex (laneIndex),
        .lastLane  (lastLane),
        .stallOut  (stallOut),
        .fifoCount (fifoCount),
        .overflow  (overflow)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vector_t seqVec(input int first);
        vector_t v;
        for (int k = 0; k < VECTOR_SIZE; k++) v[k] = DATA_WIDTH'(first + k);
        return v;
    endfunction

    function automatic vector_t randVec();
        vector_t v;
        for (int k = 0; k < VECTOR_SIZE; k++) v[k] = DATA_WIDTH'($urandom);
        return v;
    endfunction

    task automatic modelReset();
        mq.delete();
        mBusy = 1'b0;
        mCur  = '0;
        mLane = 0;
        mOvf  = 1'b0;
    endtask

    task automatic modelClock(input bit flag, input vector_t vec, input bit ready);
        bit pop;
        bit acc;
        pop = (mq.size() > 0) && (!mBusy || (ready && mLane == VECTOR_SIZE - 1));
        acc = flag && ((mq.size() < FIFO_DEPTH) || pop);
        if (flag && !acc) mOvf = 1'b1;
        if (mBusy && ready && mLane < VECTOR_SIZE - 1) begin
            mLane++;
        end else if (pop) begin
            mCur  = mq.pop_front();
            mLane = 0;
            mBusy = 1'b1;
        end else if (mBusy && ready) begin
            mBusy = 1'b0;
        end
        if (acc) mq.push_back(vec);
    endtask

    task automatic stepCycle(input bit flag, input vector_t vec, input bit ready);
        outFlag   = flag;
        outBus    = vec;
        laneReady = ready;
        @(posedge clock);
        modelClock(flag, vec, ready);
        #1;
    endtask

    task automatic doReset();
        outFlag   = 1'b0;
        laneReady = 1'b0;
        outBus    = '0;
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        #1;
        vectorsApplied++; if (laneValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", laneValid); end
        vectorsApplied++; if (laneData !== '0) begin miscompares++; $display("FAIL reset_data: got %0h want 0", laneData); end
        vectorsApplied++; if (laneIndex !== '0) begin miscompares++; $display("FAIL reset_index: got %0d want 0", laneIndex); end
        vectorsApplied++; if (lastLane !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %0b want 0", lastLane); end
        vectorsApplied++; if (stallOut !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0b want 0", stallOut); end
        vectorsApplied++; if (fifoCount !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifoCount); end
        vectorsApplied++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single();
        doReset();
        stepCycle(1'b1, seqVec(1), 1'b1);
        vectorsApplied++; if (laneValid !== 1'b0) begin miscompares++; $display("FAIL single_nobypass: valid got %0b want 0", laneValid); end
        vectorsApplied++; if (fifoCount !== COUNT_W'(1)) begin miscompares++; $display("FAIL single_count1: got %0d want 1", fifoCount); end
        for (int k = 0; k < VECTOR_SIZE; k++) begin
            stepCycle(1'b0, '0, 1'b1);
            vectorsApplied++; if (laneValid !== 1'b1) begin miscompares++; $display("FAIL single_valid lane %0d: got %0b want 1", k, laneValid); end
            vectorsApplied++; if (laneData !== DATA_WIDTH'(k + 1)) begin miscompares++; $display("FAIL single_data lane %0d: got %0h want %0h", k, laneData, k + 1); end
            vectorsApplied++; if (laneIndex !== LANE_IDX_W'(k)) begin miscompares++; $display("FAIL single_index: got %0d want %0d", laneIndex, k); end
            vectorsApplied++; if (lastLane !== 1'(k == VECTOR_SIZE - 1)) begin miscompares++; $display("FAIL single_last lane %0d: got %0b", k, lastLane); end
        end
        stepCycle(1'b0, '0, 1'b1);
        vectorsApplied++; if (laneValid !== 1'b0) begin miscompares++; $display("FAIL single_end_valid: got %0b want 0", laneValid); end
        vectorsApplied++; if (fifoCount !== '0) begin miscompares++; $display("FAIL single_end_count: got %0d want 0", fifoCount); end
    endtask

    task automatic test_backpressure();
        int    pat[4] = '{1, 0, 0, 1};
        int    hs = 0;
        bit    r;
        bit    wasValid;
        lane_t dataBefore;
        logic [LANE_IDX_W-1:0] idxBefore;
        doReset();
        stepCycle(1'b1, seqVec(1), 1'b0);
        for (int c = 0; c < 60 && hs < VECTOR_SIZE; c++) begin
            r          = (pat[c % 4] != 0);
            wasValid   = laneValid;
            dataBefore = laneData;
            idxBefore  = laneIndex;
            if (wasValid && r) begin
                vectorsApplied++; if (laneData !== DATA_WIDTH'(hs + 1)) begin miscompares++; $display("FAIL bp_handshake %0d: got %0h want %0h", hs, laneData, hs + 1); end
                hs++;
            end
            stepCycle(1'b0, '0, r);
            if (wasValid && !r) begin
                vectorsApplied++; if (laneValid !== 1'b1 || laneData !== dataBefore || laneIndex !== idxBefore) begin
                    miscompares++; $display("FAIL bp_hold: got v=%0b d=%0h i=%0d want v=1 d=%0h i=%0d", laneValid, laneData, laneIndex, dataBefore, idxBefore);
                end
            end
        end
        vectorsApplied++; if (hs != VECTOR_SIZE) begin miscompares++; $display("FAIL bp_count: got %0d handshakes want %0d", hs, VECTOR_SIZE); end
        vectorsApplied++; if (laneValid !== 1'b0) begin miscompares++; $display("FAIL bp_end_valid: got %0b want 0", laneValid); end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int first = -1;
        int last = -1;
        int expv;
        doReset();
        stepCycle(1'b1, seqVec(16'h10), 1'b1);
        stepCycle(1'b1, seqVec(16'h20), 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (laneValid === 1'b1) begin
                expv = (got < VECTOR_SIZE) ? 16'h10 + got : 16'h20 + got - VECTOR_SIZE;
                vectorsApplied++; if (laneData !== DATA_WIDTH'(expv)) begin miscompares++; $display("FAIL b2b_data %0d: got %0h want %0h", got, laneData, expv); end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            stepCycle(1'b0, '0, 1'b1);
        end
        vectorsApplied++; if (got != 2 * VECTOR_SIZE) begin miscompares++; $display("FAIL b2b_count: got %0d lanes want %0d", got, 2 * VECTOR_SIZE); end
        vectorsApplied++; if (last - first != 2 * VECTOR_SIZE - 1) begin miscompares++; $display("FAIL b2b_gap: got span %0d want %0d", last - first, 2 * VECTOR_SIZE - 1); end
    endtask

    task automatic test_stall_overflow();
        vector_t v[6];
        int      expCount[6] = '{1, 1, 2, 3, 4, 4};
        int      expStall[6] = '{0, 0, 0, 1, 1, 1};
        int      got = 0;
        doReset();
        for (int i = 0; i < 6; i++) begin
            v[i] = randVec();
            stepCycle(1'b1, v[i], 1'b0);
            vectorsApplied++; if (fifoCount !== COUNT_W'(expCount[i])) begin miscompares++; $display("FAIL so_count push %0d: got %0d want %0d", i, fifoCount, expCount[i]); end
            vectorsApplied++; if (stallOut !== 1'(expStall[i])) begin miscompares++; $display("FAIL so_stall push %0d: got %0b want %0d", i, stallOut, expStall[i]); end
            vectorsApplied++; if (overflow !== 1'(i == 5)) begin miscompares++; $display("FAIL so_overflow push %0d: got %0b", i, overflow); end
        end
        for (int c = 0; c < 80 && got < 5 * VECTOR_SIZE; c++) begin
            if (laneValid === 1'b1) begin
                vectorsApplied++; if (laneData !== v[got / VECTOR_SIZE][got % VECTOR_SIZE]) begin
                    miscompares++; $display("FAIL so_drain %0d: got %0h want %0h", got, laneData, v[got / VECTOR_SIZE][got % VECTOR_SIZE]);
                end
                got++;
            end
            stepCycle(1'b0, '0, 1'b1);
        end
        vectorsApplied++; if (got != 5 * VECTOR_SIZE) begin miscompares++; $display("FAIL so_drain_count: got %0d lanes want %0d", got, 5 * VECTOR_SIZE); end
        vectorsApplied++; if (laneValid !== 1'b0) begin miscompares++; $display("FAIL so_end_valid: got %0b want 0", laneValid); end
        vectorsApplied++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL so_sticky: got %0b want 1", overflow); end
        vectorsApplied++; if (stallOut !== 1'b0) begin miscompares++; $display("FAIL so_stall_release: got %0b want 0", stallOut); end
    endtask

    task automatic test_push_full_pop();
        vector_t v[5];
        vector_t ev[5];
        vector_t vNew;
        int      got = 0;
        doReset();
        for (int i = 0; i < 5; i++) begin
            v[i] = randVec();
            stepCycle(1'b1, v[i], 1'b0);
        end
        for (int c = 0; c < 10 && !(laneValid === 1'b1 && lastLane === 1'b1); c++) begin
            stepCycle(1'b0, '0, 1'b1);
        end
        vectorsApplied++; if (!(laneValid === 1'b1 && lastLane === 1'b1)) begin miscompares++; $display("FAIL fp_reach_last: got v=%0b last=%0b want 1/1", laneValid, lastLane); end
        vectorsApplied++; if (fifoCount !== COUNT_W'(4)) begin miscompares++; $display("FAIL fp_pre_count: got %0d want 4", fifoCount); end
        vNew = randVec();
        stepCycle(1'b1, vNew, 1'b1);
        vectorsApplied++; if (fifoCount !== COUNT_W'(4)) begin miscompares++; $display("FAIL fp_count: got %0d want 4", fifoCount); end
        vectorsApplied++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fp_overflow: got %0b want 0", overflow); end
        ev = '{v[1], v[2], v[3], v[4], vNew};
        for (int c = 0; c < 60 && got < 5 * VECTOR_SIZE; c++) begin
            if (laneValid === 1'b1) begin
                vectorsApplied++; if (laneData !== ev[got / VECTOR_SIZE][got % VECTOR_SIZE]) begin
                    miscompares++; $display("FAIL fp_drain %0d: got %0h want %0h", got, laneData, ev[got / VECTOR_SIZE][got % VECTOR_SIZE]);
                end
                got++;
            end
            stepCycle(1'b0, '0, 1'b1);
        end
        vectorsApplied++; if (got != 5 * VECTOR_SIZE) begin miscompares++; $display("FAIL fp_drain_count: got %0d want %0d", got, 5 * VECTOR_SIZE); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        doReset();
        stepCycle(1'b1, seqVec(16'h100), 1'b1);
        stepCycle(1'b1, seqVec(16'h200), 1'b1);
        stepCycle(1'b1, seqVec(16'h300), 1'b1);
        stepCycle(1'b0, '0, 1'b1);
        vectorsApplied++; if (laneIndex !== LANE_IDX_W'(2) || laneData !== DATA_WIDTH'(16'h102)) begin miscompares++; $display("FAIL rm_pre_lane: got i=%0d d=%0h want 2/102", laneIndex, laneData); end
        vectorsApplied++; if (fifoCount !== COUNT_W'(2)) begin miscompares++; $display("FAIL rm_pre_count: got %0d want 2", fifoCount); end
        #3;
        reset = 1'b1;
        modelReset();
        #1;
        vectorsApplied++; if ({laneValid, laneData, laneIndex, lastLane, stallOut, fifoCount, overflow} !== '0) begin
            miscompares++; $display("FAIL rm_async: got v=%0b d=%0h i=%0d l=%0b s=%0b c=%0d o=%0b want all 0", laneValid, laneData, laneIndex, lastLane, stallOut, fifoCount, overflow);
        end
        #3;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            stepCycle(1'b0, '0, 1'b1);
            if (laneValid !== 1'b0) seen++;
        end
        vectorsApplied++; if (seen != 0) begin miscompares++; $display("FAIL rm_no_emit: got %0d valid cycles want 0", seen); end
        stepCycle(1'b1, seqVec(16'h40), 1'b1);
        stepCycle(1'b0, '0, 1'b1);
        vectorsApplied++; if (laneValid !== 1'b1 || laneData !== DATA_WIDTH'(16'h40)) begin miscompares++; $display("FAIL rm_restart: got v=%0b d=%0h want 1/40", laneValid, laneData); end
    endtask

    task automatic test_random();
        bit flag;
        bit ready;
        int pr;
        doReset();
        for (int c = 0; c < 600; c++) begin
            pr    = ((c / 100) % 2 == 0) ? 25 : 85;
            flag  = ($urandom_range(0, 99) < 45);
            ready = ($urandom_range(0, 99) < pr);
            stepCycle(flag, randVec(), ready);
            vectorsApplied++; if (laneValid !== 1'(mBusy)) begin miscompares++; $display("FAIL rnd_valid cyc %0d: got %0b want %0b", c, laneValid, mBusy); end
            if (mBusy) begin
                vectorsApplied++; if (laneData !== mCur[mLane] || laneIndex !== LANE_IDX_W'(mLane) || lastLane !== 1'(mLane == VECTOR_SIZE - 1)) begin
                    miscompares++; $display("FAIL rnd_lane cyc %0d: got d=%0h i=%0d l=%0b want d=%0h i=%0d", c, laneData, laneIndex, lastLane, mCur[mLane], mLane);
                end
            end
            vectorsApplied++; if (fifoCount !== COUNT_W'(mq.size())) begin miscompares++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", c, fifoCount, mq.size()); end
            vectorsApplied++; if (stallOut !== 1'(mq.size() >= FIFO_DEPTH - STALL_MARGIN)) begin miscompares++; $display("FAIL rnd_stall cyc %0d: got %0b for %0d queued", c, stallOut, mq.size()); end
            vectorsApplied++; if (overflow !== 1'(mOvf)) begin miscompares++; $display("FAIL rnd_overflow cyc %0d: got %0b want %0b", c, overflow, mOvf); end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_stall_overflow();
        test_push_full_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
